// File: rtl/sm83_pkg.sv
// Shared sm83 bus types plus the memory-arbiter state and port encodings.
package sm83_pkg;

    typedef logic [15:0] addr_t;
    typedef logic [7:0]  data_t;

    typedef enum logic [1:0] {
        S_RR,
        S_LOCK,
        S_YIELD
    } arb_state_t;

    typedef enum logic {
        ARB_CPU,
        ARB_DMA
    } arb_port_e;

endpackage

// File: rtl/mem_arbiter.sv
// Arbitrates the single-port test memory between the CPU bus and a DMA port:
// combinational grant, one-cycle registered read data, bounded DMA bus locking.
module mem_arbiter
    import sm83_pkg::*;
#(
    parameter int MAX_LOCK = 16
) (
    input  logic  clk,
    input  logic  rst_n,
    input  logic  cpu_req,
    input  logic  cpu_we,
    input  addr_t cpu_addr,
    input  data_t cpu_wdata,
    output logic  cpu_gnt,
    output logic  cpu_rvalid,
    output data_t cpu_rdata,
    input  logic  dma_req,
    input  logic  dma_we,
    input  addr_t dma_addr,
    input  data_t dma_wdata,
    input  logic  dma_lock,
    output logic  dma_gnt,
    output logic  dma_rvalid,
    output data_t dma_rdata,
    output logic  mem_wen,
    output addr_t mem_r_addr,
    output addr_t mem_w_addr,
    output data_t mem_w_data,
    input  data_t mem_r_data
);

    localparam int CNT_W = $clog2(MAX_LOCK + 1);
    localparam logic [CNT_W-1:0] LOCK_MAX = CNT_W'(MAX_LOCK);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    arb_state_t       state_reg, state_next;
    arb_port_e        last_reg, last_next;
    arb_port_e        rr_pick;
    logic [CNT_W-1:0] lock_cnt_reg, lock_cnt_next;
    logic             gnt_cpu, gnt_dma;
    logic             cpu_rvalid_reg, dma_rvalid_reg;
    data_t            cpu_rdata_reg, dma_rdata_reg;

    always_comb begin
        gnt_cpu       = 1'b0;
        gnt_dma       = 1'b0;
        state_next    = state_reg;
        last_next     = last_reg;
        lock_cnt_next = lock_cnt_reg;
        rr_pick       = ARB_DMA;
        if (cpu_req && dma_req) begin
            rr_pick = (last_reg == ARB_DMA) ? ARB_CPU : ARB_DMA;
        end else if (cpu_req) begin
            rr_pick = ARB_CPU;
        end

        // Nothing is granted while reset is held, so the memory sees no access.
        if (rst_n) begin
            if (state_reg == S_LOCK) begin
                last_next = ARB_DMA;
                gnt_dma   = dma_req;
                if (dma_req && dma_lock) begin
                    if (lock_cnt_reg != LOCK_MAX) begin
                        lock_cnt_next = lock_cnt_reg + 1'b1;
                    end
                    if (lock_cnt_next == LOCK_MAX) begin
                        state_next = S_YIELD;
                    end
                end else begin
                    state_next    = S_RR;
                    lock_cnt_next = '0;
                end
            end else if (state_reg == S_YIELD && cpu_req) begin
                gnt_cpu       = 1'b1;
                state_next    = S_RR;
                last_next     = ARB_CPU;
                lock_cnt_next = '0;
            end else if (cpu_req || dma_req) begin
                // Round-robin; S_YIELD without a CPU request also lands here.
                gnt_cpu   = (rr_pick == ARB_CPU);
                gnt_dma   = (rr_pick == ARB_DMA);
                last_next = rr_pick;
                if (rr_pick == ARB_DMA && dma_lock) begin
                    lock_cnt_next = CNT_ONE;
                    state_next    = (MAX_LOCK == 1) ? S_YIELD : S_LOCK;
                end else begin
                    state_next    = S_RR;
                    lock_cnt_next = '0;
                end
            end
        end
    end

    assign cpu_gnt    = gnt_cpu;
    assign dma_gnt    = gnt_dma;
    assign mem_wen    = (gnt_cpu && cpu_we) || (gnt_dma && dma_we);
    assign mem_r_addr = gnt_cpu ? cpu_addr  : (gnt_dma ? dma_addr  : '0);
    assign mem_w_addr = gnt_cpu ? cpu_addr  : (gnt_dma ? dma_addr  : '0);
    assign mem_w_data = gnt_cpu ? cpu_wdata : (gnt_dma ? dma_wdata : '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= S_RR;
            last_reg       <= ARB_DMA;
            lock_cnt_reg   <= '0;
            cpu_rvalid_reg <= 1'b0;
            dma_rvalid_reg <= 1'b0;
            cpu_rdata_reg  <= '0;
            dma_rdata_reg  <= '0;
        end else begin
            state_reg      <= state_next;
            last_reg       <= last_next;
            lock_cnt_reg   <= lock_cnt_next;
            cpu_rvalid_reg <= gnt_cpu && !cpu_we;
            dma_rvalid_reg <= gnt_dma && !dma_we;
            if (gnt_cpu && !cpu_we) begin
                cpu_rdata_reg <= mem_r_data;
            end
            if (gnt_dma && !dma_we) begin
                dma_rdata_reg <= mem_r_data;
            end
        end
    end

    assign cpu_rvalid = cpu_rvalid_reg;
    assign cpu_rdata  = cpu_rdata_reg;
    assign dma_rvalid = dma_rvalid_reg;
    assign dma_rdata  = dma_rdata_reg;

endmodule
